conv3x3_bin_layer: RTL

- Parametrised 3x3 valid-padding convolution layer with binarised output.
- Accepts a raster-order pixel stream and forms 3x3 windows with internal line buffers.
- Computes CH signed sums using +/-1 weights and thresholds each sum against a per-channel value, giving one output bit per channel.
- Sits at the head of the MNIST pipeline, feeding the pooling/conv2 stages.

---
 rtl/conv3x3_bin_layer_if.sv | 46 ++++
 rtl/conv3x3_bin_layer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_bin_layer_if.sv
// ---------------------------------------------------------------------------
// conv3x3_bin_layer_if
// Pixel-stream / binarised-result bundle for conv3x3_bin_layer.
//   valid_in   : pixel_in valid this cycle (no backpressure)
//   sof_in     : start of frame, qualified by valid_in
//   pixel_in   : unsigned pixel, raster order
//   conv_out   : one thresholded bit per channel
//   valid_out  : conv_out valid
//   frame_done : pulse with the last valid_out of a frame
//   acc_out    : raw per-channel signed sums, channel c at [c*ACC_W +: ACC_W]
//                (present only when CONV3X3_ACC_OUT_EN is defined)
// Modports: master = stream source / result sink, slave = the layer.
// ---------------------------------------------------------------------------
interface conv3x3_bin_layer_if #(
  parameter int DATA_W = 8,
  parameter int CH     = 8,
  parameter int ACC_W  = DATA_W + 5
);
  logic              valid_in;
  logic              sof_in;
  logic [DATA_W-1:0] pixel_in;
  logic [CH-1:0]     conv_out;
  logic              valid_out;
  logic              frame_done;
`ifdef CONV3X3_ACC_OUT_EN
  logic [CH*ACC_W-1:0] acc_out;

  modport master (
    output valid_in, sof_in, pixel_in,
    input  conv_out, valid_out, frame_done, acc_out
  );
  modport slave (
    input  valid_in, sof_in, pixel_in,
    output conv_out, valid_out, frame_done, acc_out
  );
`else
  modport master (
    output valid_in, sof_in, pixel_in,
    input  conv_out, valid_out, frame_done
  );
  modport slave (
    input  valid_in, sof_in, pixel_in,
    output conv_out, valid_out, frame_done
  );
`endif
endinterface

// File: rtl/conv3x3_bin_layer.sv
// ---------------------------------------------------------------------------
// conv3x3_bin_layer
// 3x3 valid-padding convolution with +/-1 weights and per-channel threshold,
// producing one bit per output channel. Raster pixel stream in, windows
// formed with two line buffers and a 3x3 window register.
//
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset (control and outputs only)
//   bus     : conv3x3_bin_layer_if.slave (pixel stream in, results out)
//   weights : bit [c*9+k], 1 = +1, 0 = -1, k row-major, k=0 top-left
//   thresh  : signed threshold for channel c at [c*ACC_W +: ACC_W]
//
// Latency: a window completed by the pixel accepted at edge n shows on
// valid_out after edge n+2.
//
// Optional build macro: CONV3X3_ACC_OUT_EN adds bus.acc_out carrying the
// raw channel sums registered alongside conv_out.
// ---------------------------------------------------------------------------
module conv3x3_bin_layer #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28,
  parameter int DATA_W = 8,
  parameter int CH     = 8,
  parameter int ACC_W  = DATA_W + 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv3x3_bin_layer_if.slave    bus,
  input  logic [CH*9-1:0]       weights,
  input  logic [CH*ACC_W-1:0]   thresh
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  function automatic logic signed [ACC_W-1:0] tap_term(
    input logic [DATA_W-1:0] pix,
    input logic              w
  );
    logic signed [ACC_W-1:0] ext;
    ext = signed'({{(ACC_W-DATA_W){1'b0}}, pix});
    return w ? ext : -ext;
  endfunction

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] eff_col;
  logic [ROW_W-1:0] eff_row;
  logic             col_last;
  logic             row_last;
  logic             accept;
  logic             win_done;

  logic [DATA_W-1:0] line1 [WIDTH];
  logic [DATA_W-1:0] line2 [WIDTH];
  logic [DATA_W-1:0] win_p0 [3][3];
  logic              vld_p0;
  logic              last_p0;

  logic signed [ACC_W-1:0] sum_nxt [CH];
  logic signed [ACC_W-1:0] sum_p1  [CH];
  logic                    vld_p1;
  logic                    last_p1;
  logic [CH-1:0]           conv_nxt;

  // sof_in forces the accepted pixel to (0,0); counters continue from there.
  assign accept   = bus.valid_in;
  assign eff_col  = bus.sof_in ? '0 : col;
  assign eff_row  = bus.sof_in ? '0 : row;
  assign col_last = (eff_col == COL_W'(WIDTH - 1));
  assign row_last = (eff_row == ROW_W'(HEIGHT - 1));
  // col>=2 keeps every window inside one row, so no window spans a wrap.
  assign win_done = accept && (eff_row >= ROW_W'(2)) && (eff_col >= COL_W'(2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : eff_row + ROW_W'(1);
      end else begin
        col <= eff_col + COL_W'(1);
        row <= eff_row;
      end
    end
  end

  // ---- stage p0: line buffers and window register, shifted only on accept
  // line1 tail = same column one row up, line2 tail = two rows up.
  always_ff @(posedge clk) begin
    if (accept) begin
      line1[0] <= bus.pixel_in;
      line2[0] <= line1[WIDTH-1];
      for (int i = 1; i < WIDTH; i++) begin
        line1[i] <= line1[i-1];
        line2[i] <= line2[i-1];
      end
      for (int r = 0; r < 3; r++) begin
        win_p0[r][0] <= win_p0[r][1];
        win_p0[r][1] <= win_p0[r][2];
      end
      win_p0[0][2] <= line2[WIDTH-1];
      win_p0[1][2] <= line1[WIDTH-1];
      win_p0[2][2] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= win_done;
      last_p0 <= win_done && row_last && col_last;
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sum_nxt[c] = '0;
    end
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 9; k++) begin
        sum_nxt[c] = sum_nxt[c] + tap_term(win_p0[k/3][k%3], weights[c*9+k]);
      end
    end
  end

  // ---- stage p1: channel sums registered
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      sum_p1[c] <= sum_nxt[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      last_p1 <= vld_p0 && last_p0;
    end
  end

  always_comb begin
    conv_nxt = '0;
    for (int c = 0; c < CH; c++) begin
      conv_nxt[c] = (sum_p1[c] >= $signed(thresh[c*ACC_W +: ACC_W]));
    end
  end

`ifdef CONV3X3_ACC_OUT_EN
  logic [CH*ACC_W-1:0] acc_nxt;

  always_comb begin
    acc_nxt = '0;
    for (int c = 0; c < CH; c++) begin
      acc_nxt[c*ACC_W +: ACC_W] = sum_p1[c];
    end
  end
`endif

  // ---- stage p2: thresholded bits and flags; results hold when not valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.conv_out   <= '0;
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
`ifdef CONV3X3_ACC_OUT_EN
      bus.acc_out    <= '0;
`endif
    end else begin
      bus.valid_out  <= vld_p1;
      bus.frame_done <= vld_p1 && last_p1;
      if (vld_p1) begin
        bus.conv_out <= conv_nxt;
`ifdef CONV3X3_ACC_OUT_EN
        bus.acc_out  <= acc_nxt;
`endif
      end
    end
  end

endmodule
